fetch_unit: RTL

Instruction-fetch stage that sits directly downstream of the PC register. It consumes curr_pc and drives the PC's next_pc/enable inputs. It issues a req/ack handshake to instruction memory and loads the IF/ID pipeline register. It also handles decode stalls with a one-entry hold buffer, branch/jump redirects, and misaligned-PC exceptions.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC register, runs the imem req/ack handshake
// and loads IF/ID, with a one-entry hold buffer, redirect draining and misaligned-PC traps.
module fetch_unit #(
   parameter logic [31:0] START_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] curr_pc,
   output logic [31:0] next_pc,
   output logic        pc_enable,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        id_stall,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        id_exc
);

   typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_EXC} state_t;

   state_t      state;
   logic [31:0] req_addr;
   logic [31:0] hold_instr;
   logic [31:0] hold_pc;

   logic        misaligned;
   logic        accept;
   logic        fetch_ack;
   logic [31:0] fetch_addr;
   logic [31:0] fetch_plus4;

   always_comb begin
      misaligned  = curr_pc[1:0] != 2'b00;
      accept      = !id_valid || !id_stall;
      fetch_addr  = (state == S_REQ) ? curr_pc : req_addr;
      fetch_plus4 = fetch_addr + 32'd4;
      imem_addr   = fetch_addr;

      case (state)
         S_REQ:          imem_req = !misaligned;
         S_WAIT, S_DRAIN: imem_req = 1'b1;
         default:        imem_req = 1'b0;
      endcase
      if (rst) imem_req = 1'b0;

      fetch_ack = imem_req && imem_ack && (state == S_REQ || state == S_WAIT);

      pc_enable = 1'b0;
      next_pc   = curr_pc;
      if (!rst) begin
         if (redirect) begin
            pc_enable = 1'b1;
            next_pc   = redirect_target;
         end else if (fetch_ack) begin
            pc_enable = 1'b1;
            next_pc   = fetch_plus4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_REQ;
         req_addr    <= '0;
         hold_instr  <= '0;
         hold_pc     <= '0;
         id_valid    <= 1'b0;
         id_instr    <= '0;
         id_pc       <= START_ADDR;
         id_pc_plus4 <= START_ADDR + 32'd4;
         id_exc      <= 1'b0;
      end else begin
         if (id_valid && !id_stall) id_valid <= 1'b0;
         if (state == S_REQ && !misaligned) req_addr <= curr_pc;

         if (redirect) begin
            id_valid   <= 1'b0;
            id_exc     <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
            // Only a request still outstanding on the bus forces a drain.
            case (state)
               S_REQ, S_WAIT: state <= (imem_req && !imem_ack) ? S_DRAIN : S_REQ;
               S_DRAIN:       state <= imem_ack ? S_REQ : S_DRAIN;
               default:       state <= S_REQ;
            endcase
         end else begin
            case (state)
               S_REQ, S_WAIT: begin
                  if (state == S_REQ && misaligned) begin
                     if (accept) begin
                        id_valid    <= 1'b1;
                        id_instr    <= '0;
                        id_pc       <= curr_pc;
                        id_pc_plus4 <= curr_pc + 32'd4;
                        id_exc      <= 1'b1;
                        state       <= S_EXC;
                     end
                  end else if (imem_ack) begin
                     if (accept) begin
                        id_valid    <= 1'b1;
                        id_instr    <= imem_rdata;
                        id_pc       <= fetch_addr;
                        id_pc_plus4 <= fetch_plus4;
                        id_exc      <= 1'b0;
                        state       <= S_REQ;
                     end else begin
                        hold_instr <= imem_rdata;
                        hold_pc    <= fetch_addr;
                        state      <= S_HOLD;
                     end
                  end else begin
                     state <= S_WAIT;
                  end
               end
               S_HOLD: begin
                  if (accept) begin
                     id_valid    <= 1'b1;
                     id_instr    <= hold_instr;
                     id_pc       <= hold_pc;
                     id_pc_plus4 <= hold_pc + 32'd4;
                     id_exc      <= 1'b0;
                     state       <= S_REQ;
                  end
               end
               S_DRAIN: if (imem_ack) state <= S_REQ;
               S_EXC:   state <= S_EXC;
               default: state <= S_REQ;
            endcase
         end
      end
   end

endmodule
